// File: rtl/proto_cmd_bridge_if.sv
// Bus bundle for proto_cmd_bridge: RX FIFO read port, TX FIFO write port,
// CSR master bus and status. The master modport is the bridge side.
`timescale 1ns/1ps

interface proto_cmd_bridge_if #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CSR_DATA_W = 32
);
  // RX FIFO read port
  logic                  rxfifo_rd;
  logic [7:0]            rxfifo_data;
  logic                  rxfifo_valid;
  logic                  rxfifo_empty;
  // TX FIFO write port
  logic [7:0]            txfifo_data;
  logic                  txfifo_wr;
  logic                  txfifo_full;
  // CSR bus
  logic [ADDR_W-1:0]     csr_addr;
  logic [CSR_DATA_W-1:0] csr_wdata;
  logic                  csr_wen;
  logic                  csr_ren;
  logic [CSR_DATA_W-1:0] csr_rdata;
  logic                  csr_rvalid;
  // Status
  logic                  busy;
  logic [7:0]            err_cnt;

  modport master (
    output rxfifo_rd,
    input  rxfifo_data,
    input  rxfifo_valid,
    input  rxfifo_empty,
    output txfifo_data,
    output txfifo_wr,
    input  txfifo_full,
    output csr_addr,
    output csr_wdata,
    output csr_wen,
    output csr_ren,
    input  csr_rdata,
    input  csr_rvalid,
    output busy,
    output err_cnt
  );

  modport slave (
    input  rxfifo_rd,
    output rxfifo_data,
    output rxfifo_valid,
    output rxfifo_empty,
    input  txfifo_data,
    input  txfifo_wr,
    output txfifo_full,
    input  csr_addr,
    input  csr_wdata,
    input  csr_wen,
    input  csr_ren,
    output csr_rdata,
    output csr_rvalid,
    input  busy,
    input  err_cnt
  );
endinterface

// File: rtl/proto_cmd_bridge.sv
// proto_cmd_bridge: parses host command frames from the RX FIFO, runs
// single-beat CSR writes/reads and returns read data through the TX FIFO.
// Frame: CMD (01 write / 02 read), ADDR bytes MSB first, DATA bytes (write).
// Optional feature macro: PROTO_CMD_WRITE_ACK_EN (emit 8'hAC after each write).
`timescale 1ns/1ps

module proto_cmd_bridge #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CSR_DATA_W = 32,
  parameter int unsigned RD_TIMEOUT = 255,
  parameter logic [31:0] TO_DATA    = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  proto_cmd_bridge_if.master bus
);

  localparam int unsigned           ADDR_BYTES = ADDR_W / 8;
  localparam int unsigned           DATA_BYTES = CSR_DATA_W / 8;
  localparam int unsigned           TO_W       = $clog2(RD_TIMEOUT + 1);
  localparam logic [CSR_DATA_W-1:0] TO_WORD    = CSR_DATA_W'(TO_DATA);
  localparam logic [7:0]            CMD_WR     = 8'h01;
  localparam logic [7:0]            CMD_RD     = 8'h02;
`ifdef PROTO_CMD_WRITE_ACK_EN
  localparam logic [7:0]            ACK_BYTE   = 8'hAC;
`endif

  typedef enum logic [2:0] {
    IDLE_S,
    ADDR_S,
    DATA_S,
    BUS_WR_S,
    BUS_RD_S,
    WAIT_RD_S,
`ifdef PROTO_CMD_WRITE_ACK_EN
    SEND_S,
    ACK_S
`else
    SEND_S
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  fetch_pend_q, fetch_pend_d;
  logic                  is_wr_q, is_wr_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CSR_DATA_W-1:0] wdata_q, wdata_d;
  logic [CSR_DATA_W-1:0] word_q, word_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_pend_q, tx_pend_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic fetch_en;
  logic rd_issue;
  logic byte_rx;
  logic tx_fire;
  logic err_inc;

  // RX fetch handshake: at most one read outstanding, only while parsing a frame
  always_comb begin
    fetch_en = (state_q == IDLE_S) || (state_q == ADDR_S) || (state_q == DATA_S);
    rd_issue = fetch_en && !bus.rxfifo_empty && !fetch_pend_q;
    byte_rx  = fetch_pend_q && bus.rxfifo_valid;
    tx_fire  = tx_pend_q && !bus.txfifo_full;
  end

  // Frame parser, CSR sequencing and TX byte serialiser next-state logic
  always_comb begin
    state_d      = state_q;
    fetch_pend_d = fetch_pend_q;
    is_wr_d      = is_wr_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    tx_data_d    = tx_data_q;
    tx_pend_d    = tx_pend_q;
    to_cnt_d     = to_cnt_q;
    err_inc      = 1'b0;

    if (rd_issue) begin
      fetch_pend_d = 1'b1;
    end else if (byte_rx) begin
      fetch_pend_d = 1'b0;
    end

    case (state_q)
      IDLE_S: begin
        if (byte_rx) begin
          byte_cnt_d = '0;
          if (bus.rxfifo_data == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ADDR_S;
          end else if (bus.rxfifo_data == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = ADDR_S;
          end else begin
            err_inc = 1'b1;
          end
        end
      end

      ADDR_S: begin
        if (byte_rx) begin
          addr_d = ADDR_W'({addr_q, bus.rxfifo_data});
          if (byte_cnt_q == 8'(ADDR_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = is_wr_q ? DATA_S : BUS_RD_S;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      DATA_S: begin
        if (byte_rx) begin
          wdata_d = CSR_DATA_W'({wdata_q, bus.rxfifo_data});
          if (byte_cnt_q == 8'(DATA_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = BUS_WR_S;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      BUS_WR_S: begin
`ifdef PROTO_CMD_WRITE_ACK_EN
        tx_data_d = ACK_BYTE;
        tx_pend_d = 1'b1;
        state_d   = ACK_S;
`else
        state_d   = IDLE_S;
`endif
      end

      BUS_RD_S: begin
        to_cnt_d = TO_W'(RD_TIMEOUT);
        state_d  = WAIT_RD_S;
      end

      // Response on the expiry cycle still wins over the timeout word.
      WAIT_RD_S: begin
        if (bus.csr_rvalid) begin
          word_d  = bus.csr_rdata;
          state_d = SEND_S;
        end else if (to_cnt_q == TO_W'(1)) begin
          word_d  = TO_WORD;
          err_inc = 1'b1;
          state_d = SEND_S;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end

      // First cycle stages byte 0 into the holding register; each accepted
      // write then stages the next byte, so a full FIFO simply holds it.
      SEND_S: begin
        if (!tx_pend_q) begin
          tx_data_d  = word_q[CSR_DATA_W-1 -: 8];
          word_d     = CSR_DATA_W'({word_q, 8'h00});
          tx_pend_d  = 1'b1;
          byte_cnt_d = 8'd1;
        end else if (tx_fire) begin
          if (byte_cnt_q == 8'(DATA_BYTES)) begin
            tx_pend_d  = 1'b0;
            byte_cnt_d = '0;
            state_d    = IDLE_S;
          end else begin
            tx_data_d  = word_q[CSR_DATA_W-1 -: 8];
            word_d     = CSR_DATA_W'({word_q, 8'h00});
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

`ifdef PROTO_CMD_WRITE_ACK_EN
      ACK_S: begin
        if (tx_fire) begin
          tx_pend_d = 1'b0;
          state_d   = IDLE_S;
        end
      end
`endif

      default: begin
        state_d = IDLE_S;
      end
    endcase

    wen_d = (state_d == BUS_WR_S);
    ren_d = (state_d == BUS_RD_S);

    if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE_S;
      fetch_pend_q <= 1'b0;
      is_wr_q      <= 1'b0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      tx_data_q    <= '0;
      tx_pend_q    <= 1'b0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      to_cnt_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_pend_d;
      is_wr_q      <= is_wr_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      tx_data_q    <= tx_data_d;
      tx_pend_q    <= tx_pend_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      to_cnt_q     <= to_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.rxfifo_rd   = rd_issue && !rst;
  assign bus.txfifo_wr   = tx_fire && !rst;
  assign bus.txfifo_data = tx_data_q;
  assign bus.csr_addr    = addr_q;
  assign bus.csr_wdata   = wdata_q;
  assign bus.csr_wen     = wen_q;
  assign bus.csr_ren     = ren_q;
  assign bus.busy        = (state_q != IDLE_S);
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_proto_cmd_bridge.sv
// Scoreboard bench for proto_cmd_bridge: stimulus pushes expected CSR
// writes, CSR reads and TX bytes into queues; a monitor pops and compares.
`timescale 1ns/1ps

module tb_proto_cmd_bridge;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned CSR_DATA_W = 32;
  localparam int unsigned RD_TIMEOUT = 16;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  proto_cmd_bridge_if #(.ADDR_W(ADDR_W), .CSR_DATA_W(CSR_DATA_W)) bif ();

  proto_cmd_bridge #(
    .ADDR_W    (ADDR_W),
    .CSR_DATA_W(CSR_DATA_W),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.master)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];

  int          rd_delay   = 1;
  bit          rd_respond = 1'b1;
  logic [31:0] rd_word    = '0;
  int          rvalid_cyc = 0;

  int tx_cnt       = 0;
  int tx_mark      = 0;
  int tx_first_cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RX FIFO model: read enable seen in cycle c returns data in cycle c+1
  initial begin
    bit take;
    bif.rxfifo_valid = 1'b0;
    bif.rxfifo_data  = '0;
    bif.rxfifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      take = bif.rxfifo_rd;
      @(posedge clk);
      #1;
      if (take && rx_q.size() > 0) begin
        bif.rxfifo_data  = rx_q.pop_front();
        bif.rxfifo_valid = 1'b1;
      end else begin
        bif.rxfifo_valid = 1'b0;
      end
      bif.rxfifo_empty = (rx_q.size() == 0);
    end
  end

  // CSR read responder: rvalid rd_delay cycles after the csr_ren cycle
  initial begin
    bif.csr_rvalid = 1'b0;
    bif.csr_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bif.csr_ren && rd_respond) begin
        repeat (rd_delay) @(posedge clk);
        #1;
        bif.csr_rvalid = 1'b1;
        bif.csr_rdata  = rd_word;
        rvalid_cyc     = cyc;
        @(posedge clk);
        #1;
        bif.csr_rvalid = 1'b0;
        bif.csr_rdata  = '0;
      end
    end
  end

  // Monitor: compares every DUT output event against the scoreboard queues
  initial begin
    logic prev_valid;
    logic prev_rd;
    wr_t  w;
    prev_valid = 1'b0;
    prev_rd    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bif.txfifo_wr) begin
          if (tx_cnt == tx_mark) tx_first_cyc = cyc;
          tx_cnt++;
          check("tx_wr_while_full", 64'(bif.txfifo_full), 64'd0);
          if (exp_tx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: actual=%0h required=none", bif.txfifo_data);
          end else begin
            check("tx_byte", 64'(bif.txfifo_data), 64'(exp_tx.pop_front()));
          end
        end
        if (bif.csr_wen) begin
          check("wen_after_last_valid", 64'(prev_valid), 64'd1);
          if (exp_wr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wen_unexpected: actual=%0h required=none", bif.csr_addr);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", 64'(bif.csr_addr), 64'(w.a));
            check("wr_data", 64'(bif.csr_wdata), 64'(w.d));
          end
        end
        if (bif.csr_ren) begin
          if (exp_rd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ren_unexpected: actual=%0h required=none", bif.csr_addr);
          end else begin
            check("rd_addr", 64'(bif.csr_addr), 64'(exp_rd.pop_front()));
          end
        end
        if (bif.rxfifo_rd) begin
          check("rd_when_empty", 64'(bif.rxfifo_empty), 64'd0);
          check("rd_while_pending", 64'(prev_rd), 64'd0);
        end
      end
      prev_valid = bif.rxfifo_valid;
      prev_rd    = bif.rxfifo_rd;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((bif.busy || rx_q.size() != 0 || bif.rxfifo_valid || exp_tx.size() != 0 ||
            exp_wr.size() != 0 || exp_rd.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(n >= budget), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_read(input logic [15:0] a, input logic [31:0] d);
    exp_rd.push_back(a);
    exp_tx = {exp_tx, d[31:24], d[23:16], d[15:8], d[7:0]};
  endtask

  initial begin
    int n;
    int n0;
    wr_t w;
    bif.txfifo_full = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rxfifo_rd", 64'(bif.rxfifo_rd), 64'd0);
    check("rst_txfifo_wr", 64'(bif.txfifo_wr), 64'd0);
    check("rst_txfifo_data", 64'(bif.txfifo_data), 64'd0);
    check("rst_csr_wen", 64'(bif.csr_wen), 64'd0);
    check("rst_csr_ren", 64'(bif.csr_ren), 64'd0);
    check("rst_csr_addr", 64'(bif.csr_addr), 64'd0);
    check("rst_csr_wdata", 64'(bif.csr_wdata), 64'd0);
    check("rst_busy", 64'(bif.busy), 64'd0);
    check("rst_err_cnt", 64'(bif.err_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Write frame
    w = '{a: 16'h1234, d: 32'hAABBCCDD};
    exp_wr.push_back(w);
`ifdef PROTO_CMD_WRITE_ACK_EN
    exp_tx.push_back(8'hAC);
`endif
    rx_q = {rx_q, 8'h01, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wait_done("write1", 200);
    check("addr_hold", 64'(bif.csr_addr), 64'h1234);
    check("wdata_hold", 64'(bif.csr_wdata), 64'hAABBCCDD);
    check("err_after_write", 64'(bif.err_cnt), 64'd0);

    // Read, bus answers after 3 cycles
    rd_delay = 3; rd_word = 32'h01020304;
    expect_read(16'h0010, 32'h01020304);
    rx_q = {rx_q, 8'h02, 8'h00, 8'h10};
    wait_done("read1", 200);
    check("err_after_read", 64'(bif.err_cnt), 64'd0);

    // Read, zero-wait bus: first TX byte two cycles after rvalid
    rd_delay = 1; rd_word = 32'h11223344;
    tx_mark = tx_cnt;
    expect_read(16'h0020, 32'h11223344);
    rx_q = {rx_q, 8'h02, 8'h00, 8'h20};
    wait_done("read_zw", 200);
    check("rd_latency", 64'(tx_first_cyc - rvalid_cyc), 64'd2);

    // Read, bus never answers
    rd_respond = 1'b0;
    expect_read(16'h0030, 32'hDEADBEEF);
    rx_q = {rx_q, 8'h02, 8'h00, 8'h30};
    wait_done("read_to", 300);
    check("err_after_timeout", 64'(bif.err_cnt), 64'd1);
    rd_respond = 1'b1;

    // Response on the last allowed cycle wins
    rd_delay = RD_TIMEOUT; rd_word = 32'h55667788;
    expect_read(16'h0031, 32'h55667788);
    rx_q = {rx_q, 8'h02, 8'h00, 8'h31};
    wait_done("read_edge", 300);
    check("err_after_edge", 64'(bif.err_cnt), 64'd1);

    // Response one cycle too late: timeout word, late rvalid ignored
    rd_delay = RD_TIMEOUT + 1; rd_word = 32'h99999999;
    expect_read(16'h0032, 32'hDEADBEEF);
    rx_q = {rx_q, 8'h02, 8'h00, 8'h32};
    wait_done("read_late", 300);
    check("err_after_late", 64'(bif.err_cnt), 64'd2);

    // Bad command byte dropped, following read executes
    rd_delay = 2; rd_word = 32'hCAFEF00D;
    expect_read(16'h0001, 32'hCAFEF00D);
    rx_q = {rx_q, 8'h7F, 8'h02, 8'h00, 8'h01};
    wait_done("bad_cmd", 200);
    check("err_after_bad", 64'(bif.err_cnt), 64'd3);

    // TX full held for 10 cycles in the middle of SEND_S
    rd_delay = 1; rd_word = 32'hA1B2C3D4;
    tx_mark = tx_cnt;
    expect_read(16'h0040, 32'hA1B2C3D4);
    rx_q = {rx_q, 8'h02, 8'h00, 8'h40};
    n = 0;
    while (tx_cnt == tx_mark && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("full_first_byte_timeout", 64'(n >= 200), 64'd0);
    @(posedge clk);
    #1 bif.txfifo_full = 1'b1;
    n0 = tx_cnt;
    repeat (10) @(negedge clk);
    check("no_tx_while_full", 64'(tx_cnt - n0), 64'd0);
    check("busy_while_full", 64'(bif.busy), 64'd1);
    @(posedge clk);
    #1 bif.txfifo_full = 1'b0;
    wait_done("full", 200);

    // Back-to-back write and read frames already queued in the RX FIFO
    rd_delay = 2; rd_word = 32'h0BADF00D;
    w = '{a: 16'h0050, d: 32'hDEAD0001};
    exp_wr.push_back(w);
`ifdef PROTO_CMD_WRITE_ACK_EN
    exp_tx.push_back(8'hAC);
`endif
    expect_read(16'h0050, 32'h0BADF00D);
    rx_q = {rx_q, 8'h01, 8'h00, 8'h50, 8'hDE, 8'hAD, 8'h00, 8'h01, 8'h02, 8'h00, 8'h50};
    wait_done("b2b", 300);

    // Error counter saturates
    for (int i = 0; i < 260; i++) rx_q.push_back((i % 2 == 0) ? 8'h00 : 8'hFF);
    wait_done("saturate", 1000);
    check("err_saturated", 64'(bif.err_cnt), 64'hFF);

    // Reset in the middle of a write frame, then a full frame
    rx_q = {rx_q, 8'h01, 8'hAB};
    repeat (8) @(negedge clk);
    check("busy_mid_frame", 64'(bif.busy), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_err", 64'(bif.err_cnt), 64'd0);
    check("post_rst_busy", 64'(bif.busy), 64'd0);
    check("post_rst_addr", 64'(bif.csr_addr), 64'd0);
    w = '{a: 16'h5678, d: 32'h11223344};
    exp_wr.push_back(w);
`ifdef PROTO_CMD_WRITE_ACK_EN
    exp_tx.push_back(8'hAC);
`endif
    rx_q = {rx_q, 8'h01, 8'h56, 8'h78, 8'h11, 8'h22, 8'h33, 8'h44};
    wait_done("write_after_rst", 200);
    check("err_final", 64'(bif.err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
